// File: rtl/strait_bist_pkg.sv
// Shared definitions for the STRAIT array self-test sequencer: FSM states,
// the fixed pattern table and the default de-skew latency.
package strait_bist_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD_W = 2'd1,
      RUN    = 2'd2,
      DONE   = 2'd3
   } bist_state_e;

   localparam int NUM_PATTERNS = 4;
   localparam int PAT_IDX_W    = 2;

   // Entry 0 is the rightmost element.
   localparam logic [NUM_PATTERNS-1:0][7:0] PAT_W_BYTES = {8'hAA, 8'h55, 8'hFF, 8'h00};
   localparam logic [NUM_PATTERNS-1:0][7:0] PAT_A_BYTES = {8'h55, 8'hAA, 8'hFF, 8'h00};

   function automatic int default_output_latency(input int systolic_size);
      return 2 * systolic_size;
   endfunction

endpackage

// File: rtl/bist_golden_rom.sv
// Pattern table lookup: byte patterns stretched to the configured element
// widths, plus the golden column sum S * w * a for an ideal array.
module bist_golden_rom
   import strait_bist_pkg::*;
#(
   parameter int SYSTOLIC_SIZE     = 8,
   parameter int WEIGHT_WIDTH      = 8,
   parameter int ACTIVATION_WIDTH  = 8,
   parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE)
) (
   input  logic [PAT_IDX_W-1:0]         pat_idx,
   output logic [WEIGHT_WIDTH-1:0]      weight_elem,
   output logic [ACTIVATION_WIDTH-1:0]  act_elem,
   output logic [PARTIAL_SUM_WIDTH-1:0] golden_sum
);

   logic [7:0] w_byte;
   logic [7:0] a_byte;

   assign w_byte = PAT_W_BYTES[pat_idx];
   assign a_byte = PAT_A_BYTES[pat_idx];

   // Bit i of an element repeats bit (i mod 8) of the byte, so wider
   // elements replicate the pattern and narrower ones truncate it.
   for (genvar i = 0; i < WEIGHT_WIDTH; i++) begin : g_weight_bits
      assign weight_elem[i] = w_byte[i % 8];
   end

   for (genvar i = 0; i < ACTIVATION_WIDTH; i++) begin : g_act_bits
      assign act_elem[i] = a_byte[i % 8];
   end

   assign golden_sum = PARTIAL_SUM_WIDTH'(SYSTOLIC_SIZE)
                     * PARTIAL_SUM_WIDTH'(weight_elem)
                     * PARTIAL_SUM_WIDTH'(act_elem);

endmodule

// File: rtl/bist_pattern_sequencer.sv
// Self-test sequencer: loads each pattern's weights, streams activations,
// strobes golden answers at the comparator and accumulates a sticky fault map.
module bist_pattern_sequencer
   import strait_bist_pkg::*;
#(
   parameter int SYSTOLIC_SIZE     = 8,
   parameter int WEIGHT_WIDTH      = 8,
   parameter int ACTIVATION_WIDTH  = 8,
   parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
   parameter int OUTPUT_LATENCY    = default_output_latency(SYSTOLIC_SIZE)
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     test_start,
   output logic                                     weight_load_en,
   output logic [$clog2(SYSTOLIC_SIZE)-1:0]         weight_row_idx,
   output logic [WEIGHT_WIDTH*SYSTOLIC_SIZE-1:0]    weight_row_flat,
   output logic                                     act_valid,
   output logic [ACTIVATION_WIDTH*SYSTOLIC_SIZE-1:0] act_flat,
   output logic [PARTIAL_SUM_WIDTH-1:0]             correct_answer,
   output logic                                     compare_en,
   input  logic [SYSTOLIC_SIZE-1:0]                 compared_results,
   output logic [SYSTOLIC_SIZE-1:0]                 fault_map,
   output logic                                     test_busy,
   output logic                                     test_done
);

   localparam int ROW_W = $clog2(SYSTOLIC_SIZE);
   localparam int CNT_W = $clog2(OUTPUT_LATENCY + SYSTOLIC_SIZE + 1);

   localparam logic [CNT_W-1:0]     LOAD_LAST = CNT_W'(SYSTOLIC_SIZE - 1);
   localparam logic [CNT_W-1:0]     ACT_END   = CNT_W'(SYSTOLIC_SIZE);
   localparam logic [CNT_W-1:0]     CMP_BEGIN = CNT_W'(OUTPUT_LATENCY);
   localparam logic [CNT_W-1:0]     CAP_BEGIN = CNT_W'(OUTPUT_LATENCY + 1);
   localparam logic [CNT_W-1:0]     RUN_LAST  = CNT_W'(OUTPUT_LATENCY + SYSTOLIC_SIZE);
   localparam logic [PAT_IDX_W-1:0] LAST_PAT  = PAT_IDX_W'(NUM_PATTERNS - 1);

   bist_state_e                state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [PAT_IDX_W-1:0]       pat_q, pat_d;
   logic [SYSTOLIC_SIZE-1:0]   fault_map_q, fault_map_d;

   logic                                      weight_load_en_q, weight_load_en_d;
   logic [ROW_W-1:0]                          weight_row_idx_q, weight_row_idx_d;
   logic [WEIGHT_WIDTH*SYSTOLIC_SIZE-1:0]     weight_row_flat_q, weight_row_flat_d;
   logic                                      act_valid_q, act_valid_d;
   logic [ACTIVATION_WIDTH*SYSTOLIC_SIZE-1:0] act_flat_q, act_flat_d;
   logic [PARTIAL_SUM_WIDTH-1:0]              correct_answer_q, correct_answer_d;
   logic                                      compare_en_q, compare_en_d;
   logic                                      test_busy_q, test_busy_d;
   logic                                      test_done_q, test_done_d;

   logic [WEIGHT_WIDTH-1:0]      rom_weight;
   logic [ACTIVATION_WIDTH-1:0]  rom_act;
   logic [PARTIAL_SUM_WIDTH-1:0] rom_golden;

   // Looked up with the next pattern index so the data registers line up
   // with their strobes.
   bist_golden_rom #(
      .SYSTOLIC_SIZE     (SYSTOLIC_SIZE),
      .WEIGHT_WIDTH      (WEIGHT_WIDTH),
      .ACTIVATION_WIDTH  (ACTIVATION_WIDTH),
      .PARTIAL_SUM_WIDTH (PARTIAL_SUM_WIDTH)
   ) u_golden_rom (
      .pat_idx     (pat_d),
      .weight_elem (rom_weight),
      .act_elem    (rom_act),
      .golden_sum  (rom_golden)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pat_d       = pat_q;
      fault_map_d = fault_map_q;
      case (state_q)
         IDLE, DONE: begin
            if (test_start) begin
               state_d     = LOAD_W;
               cnt_d       = '0;
               pat_d       = '0;
               fault_map_d = '0;
            end
         end
         LOAD_W: begin
            if (cnt_q == LOAD_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RUN: begin
            // Mismatch flags trail compare_en by one cycle.
            if (cnt_q >= CAP_BEGIN && cnt_q <= RUN_LAST) begin
               fault_map_d = fault_map_q | compared_results;
            end
            if (cnt_q == RUN_LAST) begin
               cnt_d = '0;
               if (pat_q == LAST_PAT) begin
                  state_d = DONE;
               end else begin
                  state_d = LOAD_W;
                  pat_d   = pat_q + PAT_IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so that the registered copies
   // describe the cycle the FSM is entering.
   always_comb begin
      weight_load_en_d  = (state_d == LOAD_W);
      weight_row_idx_d  = '0;
      weight_row_flat_d = '0;
      act_valid_d       = (state_d == RUN) && (cnt_d < ACT_END);
      act_flat_d        = '0;
      compare_en_d      = (state_d == RUN) && (cnt_d >= CMP_BEGIN) && (cnt_d < RUN_LAST);
      correct_answer_d  = '0;
      test_busy_d       = (state_d == LOAD_W) || (state_d == RUN);
      test_done_d       = (state_d == DONE);
      if (weight_load_en_d) begin
         weight_row_idx_d  = cnt_d[ROW_W-1:0];
         weight_row_flat_d = {SYSTOLIC_SIZE{rom_weight}};
      end
      if (act_valid_d) begin
         act_flat_d = {SYSTOLIC_SIZE{rom_act}};
      end
      if (compare_en_d) begin
         correct_answer_d = rom_golden;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q           <= IDLE;
         cnt_q             <= '0;
         pat_q             <= '0;
         fault_map_q       <= '0;
         weight_load_en_q  <= 1'b0;
         weight_row_idx_q  <= '0;
         weight_row_flat_q <= '0;
         act_valid_q       <= 1'b0;
         act_flat_q        <= '0;
         correct_answer_q  <= '0;
         compare_en_q      <= 1'b0;
         test_busy_q       <= 1'b0;
         test_done_q       <= 1'b0;
      end else begin
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         pat_q             <= pat_d;
         fault_map_q       <= fault_map_d;
         weight_load_en_q  <= weight_load_en_d;
         weight_row_idx_q  <= weight_row_idx_d;
         weight_row_flat_q <= weight_row_flat_d;
         act_valid_q       <= act_valid_d;
         act_flat_q        <= act_flat_d;
         correct_answer_q  <= correct_answer_d;
         compare_en_q      <= compare_en_d;
         test_busy_q       <= test_busy_d;
         test_done_q       <= test_done_d;
      end
   end

   assign weight_load_en  = weight_load_en_q;
   assign weight_row_idx  = weight_row_idx_q;
   assign weight_row_flat = weight_row_flat_q;
   assign act_valid       = act_valid_q;
   assign act_flat        = act_flat_q;
   assign correct_answer  = correct_answer_q;
   assign compare_en      = compare_en_q;
   assign fault_map       = fault_map_q;
   assign test_busy       = test_busy_q;
   assign test_done       = test_done_q;

endmodule

// File: tb/tb_bist_pattern_sequencer.sv
// Self-checking bench for bist_pattern_sequencer: a cycle-position model of
// the 132-cycle sequence checked every cycle, plus hand-computed pins.
module tb_bist_pattern_sequencer;

   localparam int S   = 8;
   localparam int PSW = 19;
   localparam int PER = 33;
   localparam int TOT = 132;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             test_start;
   logic [S-1:0]     compared_results;
   logic             weight_load_en;
   logic [2:0]       weight_row_idx;
   logic [8*S-1:0]   weight_row_flat;
   logic             act_valid;
   logic [8*S-1:0]   act_flat;
   logic [PSW-1:0]   correct_answer;
   logic             compare_en;
   logic [S-1:0]     fault_map;
   logic             test_busy;
   logic             test_done;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   // Model: position within the sequence and accumulated faults.
   bit         m_busy  = 1'b0;
   bit         m_done  = 1'b0;
   int         m_k     = 0;
   logic [7:0] m_fault = 8'h00;

   logic [7:0] pat_w [4] = '{8'h00, 8'hFF, 8'h55, 8'hAA};
   logic [7:0] pat_a [4] = '{8'h00, 8'hFF, 8'hAA, 8'h55};
   logic [7:0] inj   [4][8];

   always #5 clk = ~clk;

   bist_pattern_sequencer #(
      .SYSTOLIC_SIZE    (S),
      .WEIGHT_WIDTH     (8),
      .ACTIVATION_WIDTH (8)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .test_start       (test_start),
      .weight_load_en   (weight_load_en),
      .weight_row_idx   (weight_row_idx),
      .weight_row_flat  (weight_row_flat),
      .act_valid        (act_valid),
      .act_flat         (act_flat),
      .correct_answer   (correct_answer),
      .compare_en       (compare_en),
      .compared_results (compared_results),
      .fault_map        (fault_map),
      .test_busy        (test_busy),
      .test_done        (test_done)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy  <= 1'b0;
         m_done  <= 1'b0;
         m_k     <= 0;
         m_fault <= 8'h00;
      end else if (test_start && !m_busy) begin
         m_busy  <= 1'b1;
         m_done  <= 1'b0;
         m_k     <= 0;
         m_fault <= 8'h00;
      end else if (m_busy) begin
         if (m_k % PER >= 25) m_fault <= m_fault | compared_results;
         if (m_k == TOT - 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end
         m_k <= m_k + 1;
      end
   end

   task automatic applyStimulus();
      int p;
      int o;
      p = m_busy ? m_k / PER : 0;
      o = m_k % PER;
      compared_results = (m_busy && o >= 25) ? inj[p][o-25] : 8'h00;
   endtask

   task automatic checkOutput();
      int p;
      int o;
      bit wle;
      bit av;
      bit ce;
      p   = m_busy ? m_k / PER : 0;
      o   = m_k % PER;
      wle = m_busy && o < 8;
      av  = m_busy && o >= 8 && o < 16;
      ce  = m_busy && o >= 24 && o < 32;
      check("weight_load_en", 64'(weight_load_en), 64'(wle));
      check("weight_row_idx", 64'(weight_row_idx), wle ? 64'(o) : 64'd0);
      check("weight_row_flat", weight_row_flat, wle ? {8{pat_w[p]}} : 64'd0);
      check("act_valid", 64'(act_valid), 64'(av));
      check("act_flat", act_flat, av ? {8{pat_a[p]}} : 64'd0);
      check("compare_en", 64'(compare_en), 64'(ce));
      check("correct_answer", 64'(correct_answer),
            ce ? longint'(S) * longint'(pat_w[p]) * longint'(pat_a[p]) : 64'd0);
      check("test_busy", 64'(test_busy), 64'(m_busy));
      check("test_done", 64'(test_done), 64'(m_done));
      check("fault_map", 64'(fault_map), 64'(m_fault));
   endtask

   initial begin
      forever begin
         @(negedge clk);
         checkOutput();
         applyStimulus();
      end
   end

   task automatic clear_inj();
      for (int p = 0; p < 4; p++)
         for (int j = 0; j < 8; j++)
            inj[p][j] = 8'h00;
   endtask

   task automatic start_pulse();
      @(negedge clk);
      test_start = 1'b1;
      @(negedge clk);
      test_start = 1'b0;
      cyc = 0;
   endtask

   task automatic goto_cycle(input int c);
      repeat (c - cyc) @(negedge clk);
      cyc = c;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_wle"},  64'(weight_load_en), 64'd0);
      check({tag, "_idx"},  64'(weight_row_idx), 64'd0);
      check({tag, "_wflat"}, weight_row_flat,    64'd0);
      check({tag, "_av"},   64'(act_valid),      64'd0);
      check({tag, "_aflat"}, act_flat,           64'd0);
      check({tag, "_ce"},   64'(compare_en),     64'd0);
      check({tag, "_ans"},  64'(correct_answer), 64'd0);
      check({tag, "_fault"}, 64'(fault_map),     64'd0);
      check({tag, "_busy"}, 64'(test_busy),      64'd0);
      check({tag, "_done"}, 64'(test_done),      64'd0);
   endtask

   initial begin
      rst_n            = 1'b1;
      test_start       = 1'b0;
      compared_results = '0;
      clear_inj();
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      #2 rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] clean run");
      start_pulse();
      check("c0_wle", 64'(weight_load_en), 64'd1);
      check("c0_idx", 64'(weight_row_idx), 64'd0);
      goto_cycle(7);
      check("c7_idx", 64'(weight_row_idx), 64'd7);
      goto_cycle(8);
      check("c8_av", 64'(act_valid), 64'd1);
      check("c8_wle", 64'(weight_load_en), 64'd0);
      goto_cycle(24);
      check("c24_ce", 64'(compare_en), 64'd1);
      check("p0_golden", 64'(correct_answer), 64'd0);
      goto_cycle(57);
      check("p1_golden", 64'(correct_answer), 64'd520200);
      goto_cycle(90);
      check("p2_golden", 64'(correct_answer), 64'd115600);
      goto_cycle(123);
      check("p3_golden", 64'(correct_answer), 64'd115600);
      goto_cycle(131);
      check("c131_busy", 64'(test_busy), 64'd1);
      check("c131_done", 64'(test_done), 64'd0);
      goto_cycle(132);
      check("c132_done", 64'(test_done), 64'd1);
      check("c132_busy", 64'(test_busy), 64'd0);
      check("c132_fault", 64'(fault_map), 64'h00);

      $display("[TB] single fault on p2 third capture");
      inj[2][2] = 8'h04;
      start_pulse();
      goto_cycle(93);
      check("p2_pre_fault", 64'(fault_map), 64'h00);
      goto_cycle(94);
      check("p2_post_fault", 64'(fault_map), 64'h04);
      goto_cycle(132);
      check("run2_done_fault", 64'(fault_map), 64'h04);
      goto_cycle(137);
      check("run2_hold_fault", 64'(fault_map), 64'h04);
      check("run2_hold_done", 64'(test_done), 64'd1);
      clear_inj();

      $display("[TB] reset during p1 RUN");
      start_pulse();
      goto_cycle(45);
      #2 rst_n = 1'b0;
      #1 check_zero("midrst");
      @(negedge clk);
      #2 rst_n = 1'b1;

      $display("[TB] clean run with ignored start and 0x81 faults");
      inj[0][0] = 8'h01;
      inj[3][7] = 8'h80;
      start_pulse();
      goto_cycle(26);
      check("p0_first_capture", 64'(fault_map), 64'h01);
      goto_cycle(50);
      test_start = 1'b1;
      @(negedge clk);
      test_start = 1'b0;
      cyc = 51;
      goto_cycle(131);
      check("run4_c131_busy", 64'(test_busy), 64'd1);
      goto_cycle(132);
      check("run4_c132_done", 64'(test_done), 64'd1);
      check("run4_fault", 64'(fault_map), 64'h81);
      clear_inj();

      $display("[TB] restart from DONE clears faults");
      start_pulse();
      check("restart_fault", 64'(fault_map), 64'h00);
      check("restart_wle", 64'(weight_load_en), 64'd1);
      check("restart_done", 64'(test_done), 64'd0);
      goto_cycle(24);
      check("restart_p0_ce", 64'(compare_en), 64'd1);
      check("restart_p0_ans", 64'(correct_answer), 64'd0);
      goto_cycle(132);
      check("restart_done_end", 64'(test_done), 64'd1);
      check("restart_fault_end", 64'(fault_map), 64'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
